// File: rtl/lsm_sequencer.sv
// lsm_sequencer: load/store-multiple register sequencer.
//
// Walks the register list of an LDM/STM-style instruction lowest register first,
// presenting one register number and one memory address per transfer. It also
// computes the final base-register writeback value. The control unit drives it
// with a small command set and branches on LSM_DETECT / LSM_END.
//
// Ports
//   CLK         in   1   rising-edge clock
//   RESET       in   1   asynchronous active-low reset
//   IR          in  32   instruction: [15:0] register list, [24] P, [23] U
//   BASE        in  32   base register value
//   LSM_EN      in   1   command enable
//   LSM_IN      in   3   command: 000 NOP, 001 LOAD, 010 SCAN, 011 ADVANCE, 100 CLEAR
//   LSM_DETECT  out  1   next register found (REG_NUM valid)
//   LSM_END     out  1   register list exhausted
//   REG_NUM     out  4   register to transfer
//   ADDR        out 32   memory address for the current transfer
//   WB_ADDR     out 32   final base writeback value
//   COUNT       out  5   transfers completed
module lsm_sequencer (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] IR,
    input  logic [31:0] BASE,
    input  logic        LSM_EN,
    input  logic [2:0]  LSM_IN,
    output logic        LSM_DETECT,
    output logic        LSM_END,
    output logic [3:0]  REG_NUM,
    output logic [31:0] ADDR,
    output logic [31:0] WB_ADDR,
    output logic [4:0]  COUNT
);

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StDone
    } state_e;

    localparam logic [2:0] CmdLoad    = 3'b001;
    localparam logic [2:0] CmdScan    = 3'b010;
    localparam logic [2:0] CmdAdvance = 3'b011;
    localparam logic [2:0] CmdClear   = 3'b100;

    state_e      state;
    logic [15:0] pending;
    logic [4:0]  n_regs;

    logic [4:0]  load_n;
    logic [31:0] load_bytes;
    logic [31:0] load_addr;
    logic [31:0] load_wb;
    logic [3:0]  first_reg;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

    // Scanning from the top down leaves the lowest set index in idx.
    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    // Start address and writeback for a LOAD. The start address is always the
    // lowest address of the block, so transfers ascend even for decrementing modes.
    always_comb begin
        load_n     = popcount16(IR[15:0]);
        load_bytes = {25'd0, load_n, 2'b00};
        load_addr  = BASE;
        load_wb    = BASE;
        unique case ({IR[24], IR[23]})
            2'b01: begin                                   // IA
                load_addr = BASE;
                load_wb   = BASE + load_bytes;
            end
            2'b11: begin                                   // IB
                load_addr = BASE + 32'd4;
                load_wb   = BASE + load_bytes;
            end
            2'b00: begin                                   // DA
                load_addr = BASE - load_bytes + 32'd4;
                load_wb   = BASE - load_bytes;
            end
            2'b10: begin                                   // DB
                load_addr = BASE - load_bytes;
                load_wb   = BASE - load_bytes;
            end
            default: begin
                load_addr = BASE;
                load_wb   = BASE;
            end
        endcase
        first_reg = lowest_set(pending);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= StIdle;
            pending    <= '0;
            n_regs     <= '0;
            LSM_DETECT <= 1'b0;
            LSM_END    <= 1'b0;
            REG_NUM    <= '0;
            ADDR       <= '0;
            WB_ADDR    <= '0;
            COUNT      <= '0;
        end else if (LSM_EN) begin
            case (LSM_IN)
                CmdLoad: begin
                    state      <= StActive;
                    pending    <= IR[15:0];
                    n_regs     <= load_n;
                    COUNT      <= '0;
                    LSM_DETECT <= 1'b0;
                    LSM_END    <= 1'b0;
                    ADDR       <= load_addr;
                    WB_ADDR    <= load_wb;
                end
                CmdScan: begin
                    if (state == StActive) begin
                        if (pending != 16'd0) begin
                            LSM_DETECT <= 1'b1;
                            REG_NUM    <= first_reg;
                        end else begin
                            LSM_DETECT <= 1'b0;
                            LSM_END    <= 1'b1;
                            state      <= StDone;
                        end
                    end
                end
                CmdAdvance: begin
                    // Only a reported register may be retired.
                    if (state == StActive && LSM_DETECT) begin
                        pending[REG_NUM] <= 1'b0;
                        ADDR             <= ADDR + 32'd4;
                        COUNT            <= COUNT + 5'd1;
                        LSM_DETECT       <= 1'b0;
                    end
                end
                CmdClear: begin
                    state      <= StIdle;
                    pending    <= '0;
                    n_regs     <= '0;
                    LSM_DETECT <= 1'b0;
                    LSM_END    <= 1'b0;
                    REG_NUM    <= '0;
                    ADDR       <= '0;
                    WB_ADDR    <= '0;
                    COUNT      <= '0;
                end
                default: ;
            endcase
        end
    end

    // n_regs is kept for debug visibility; the end condition uses pending directly.
    logic unused_bits;
    assign unused_bits = ^{IR[31:25], IR[22:16], n_regs};

endmodule
